regfile_mp: RTL and testbench

- Parametrised successor to the team's 32x32 two-read/one-write register file.
- Configurable data width, depth and read-port count.
- Registered reads with one-cycle latency and write-first bypass.
- Byte-enable writes and a sequential bulk-clear engine with a busy flag.
- Sits in the datapath as the architectural register file feeding the execute stage.

---
 rtl/regfile_mp.sv | 144 ++++++++++++++
 tb/tb_regfile_mp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file.
//   - DATA_W-wide entries, DEPTH = 2**ADDR_W, NUM_RD independent read ports.
//   - Registered reads (1-cycle latency) with write-first bypass.
//   - Byte-enable writes.
//   - Sequential bulk-clear engine (IDLE/CLEAR) with clr_busy flag.
// Optional feature macro: REGFILE_ZERO_R0_EN (entry 0 hardwired to zero).
//
// Handshake: rd_en[i] is a request strobe sampled at a rising edge; the
// response appears as a one-cycle rd_valid[i] pulse with rd_data[i] in the
// following cycle. There is no back-pressure; rd_data[i] holds between pulses.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     dbg_state
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int NBYTES = DATA_W/8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   wr_merged;
    logic                wr_fire;
    logic                clr_last;
    logic [DATA_W-1:0]   rd_next [NUM_RD];

    assign dbg_state = state;
    assign clr_last  = (clr_idx == {ADDR_W{1'b1}});

    // Byte-merge the incoming write with the current entry; decide if it lands.
    always_comb begin
        wr_merged = mem[wr_addr];
        for (int b = 0; b < NBYTES; b++) begin
            if (wr_be[b]) begin
                wr_merged[8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        wr_fire = wr_en && (state == S_IDLE) && (wr_be != '0);
`ifdef REGFILE_ZERO_R0_EN
        if (wr_addr == '0) begin
            wr_fire = 1'b0;
        end
`endif
    end

    // Clear engine: one entry per cycle, exactly DEPTH cycles, then back to IDLE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        state    <= S_CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_last) begin
                        state    <= S_IDLE;
                        clr_idx  <= '0;
                        clr_busy <= 1'b0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    clr_idx  <= '0;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage: sweep has priority; writes are dropped (not queued) during CLEAR.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    // Per-port read value: zero during a sweep, else write-first bypass, else array.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (state == S_CLEAR) begin
                rd_next[i] = '0;
            end else if (wr_fire && (rd_addr[i*ADDR_W +: ADDR_W] == wr_addr)) begin
                rd_next[i] = wr_merged;
            end else begin
                rd_next[i] = mem[rd_addr[i*ADDR_W +: ADDR_W]];
            end
`ifdef REGFILE_ZERO_R0_EN
            if (rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
                rd_next[i] = '0;
            end
`endif
        end
    end

    // Registered read ports: load on rd_en, hold otherwise; valid is a pulse.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int i = 0; i < NUM_RD; i++) begin
                if (rd_en[i]) begin
                    rd_data[i*DATA_W +: DATA_W] <= rd_next[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp (default parameters).
module tb_regfile_mp;

  logic        clk;
  logic        nrst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_valid;
  logic        clr_req;
  logic        clr_busy;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .nrst(nrst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_req(clr_req), .clr_busy(clr_busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en   = 1'b0;
    wr_be   = 4'h0;
    rd_en   = 2'b00;
    clr_req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a, input logic [31:0] e);
    rd_en[p] = 1'b1;
    rd_addr[p*5 +: 5] = a;
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  // scoreboard monitor: pop expected value whenever a port presents valid
  always @(negedge clk) begin
    if (nrst) begin
      if (rd_valid[0]) begin
        total++;
        if (exp_q0.size() == 0) begin
          bad++;
          $display("FAIL port0_unexpected_valid: got=%h want=no_valid", rd_data[31:0]);
        end else begin
          logic [31:0] e0;
          e0 = exp_q0.pop_front();
          if (rd_data[31:0] !== e0) begin
            bad++;
            $display("FAIL port0_data: got=%h want=%h", rd_data[31:0], e0);
          end
        end
      end
      if (rd_valid[1]) begin
        total++;
        if (exp_q1.size() == 0) begin
          bad++;
          $display("FAIL port1_unexpected_valid: got=%h want=no_valid", rd_data[63:32]);
        end else begin
          logic [31:0] e1;
          e1 = exp_q1.pop_front();
          if (rd_data[63:32] !== e1) begin
            bad++;
            $display("FAIL port1_data: got=%h want=%h", rd_data[63:32], e1);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int n;
    nrst    = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    idle_in();
    #12;
    check("reset_rd_data", rd_data, 64'h0);
    check("reset_rd_valid", {62'h0, rd_valid}, 64'h0);
    check("reset_clr_busy", {63'h0, clr_busy}, 64'h0);
    check("reset_state", {63'h0, dbg_state}, 64'h0);
    cyc();
    nrst = 1'b1;
    cyc();

    // full write then read, plus hold-after-pulse
    wr(5'd10, 32'h00AE5734, 4'hF); cyc(); idle_in();
    set_rd(0, 5'd10, 32'h00AE5734); cyc(); idle_in();
    cyc();
    check("hold_rd_data0", {32'h0, rd_data[31:0]}, {32'h0, 32'h00AE5734});
    check("hold_rd_valid0", {62'h0, rd_valid}, 64'h0);

    // byte-enable merge and be=0 no-op
    wr(5'd11, 32'h11223344, 4'hF); cyc(); idle_in();
    wr(5'd11, 32'hAABBCCDD, 4'b0101); cyc(); idle_in();
    set_rd(1, 5'd11, 32'h11BB33DD); cyc(); idle_in();
    wr(5'd11, 32'hFFFFFFFF, 4'h0); cyc(); idle_in();
    set_rd(0, 5'd11, 32'h11BB33DD); cyc(); idle_in();

    // write-first bypass on both ports
    wr(5'd7, 32'h0BADF00D, 4'hF); cyc(); idle_in();
    wr(5'd7, 32'hDEADBEEF, 4'hF);
    set_rd(0, 5'd7, 32'hDEADBEEF);
    set_rd(1, 5'd7, 32'hDEADBEEF);
    cyc(); idle_in();
    // partial bypass merge
    wr(5'd7, 32'h00000055, 4'b0001);
    set_rd(1, 5'd7, 32'hDEADBE55);
    cyc(); idle_in();

    // optional zero-entry behaviour, including via bypass
    wr(5'd0, 32'h12345678, 4'hF); cyc(); idle_in();
`ifdef REGFILE_ZERO_R0_EN
    set_rd(0, 5'd0, 32'h0); cyc(); idle_in();
    wr(5'd0, 32'h9ABCDEF0, 4'hF);
    set_rd(1, 5'd0, 32'h0); cyc(); idle_in();
`else
    set_rd(0, 5'd0, 32'h12345678); cyc(); idle_in();
    wr(5'd0, 32'h9ABCDEF0, 4'hF);
    set_rd(1, 5'd0, 32'h9ABCDEF0); cyc(); idle_in();
`endif

    // fill 1..31 with nonzero values
    for (int a = 1; a < 32; a++) begin
      wr(a[4:0], 32'h01010101 * a + 32'h5000, 4'hF); cyc();
    end
    idle_in();
    set_rd(0, 5'd31, 32'h01010101 * 31 + 32'h5000); cyc(); idle_in();

    // bulk clear with mid-sweep write, reads and a re-request
    clr_req = 1'b1; cyc(); idle_in();
    check("clr_state", {63'h0, dbg_state}, 64'h1);
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 5) begin
        wr(5'd3, 32'h5A5A5A5A, 4'hF);
        set_rd(0, 5'd3, 32'h0);
      end
      if (n == 8) clr_req = 1'b1;
      if (n == 12) set_rd(1, 5'd20, 32'h0);
      if (n == 31) set_rd(0, 5'd31, 32'h0);
      cyc(); idle_in();
      n++;
    end
    check("clr_busy_cycles", n, 32);
    for (int a = 0; a < 32; a += 2) begin
      set_rd(0, a[4:0], 32'h0);
      set_rd(1, 5'(a + 1), 32'h0);
      cyc(); idle_in();
    end
    cyc();

    // reset asserted at cycle 10 of a sweep
    wr(5'd5, 32'h77778888, 4'hF); cyc(); idle_in();
    clr_req = 1'b1; cyc(); idle_in();
    n = 0;
    while (clr_busy && n < 10) begin
      cyc();
      n++;
    end
    check("pre_reset_busy", {63'h0, clr_busy}, 64'h1);
    nrst = 1'b0;
    #1;
    check("midclr_reset_busy", {63'h0, clr_busy}, 64'h0);
    check("midclr_reset_valid", {62'h0, rd_valid}, 64'h0);
    check("midclr_reset_data", rd_data, 64'h0);
    check("midclr_reset_state", {63'h0, dbg_state}, 64'h0);
    cyc(); cyc();
    nrst = 1'b1;
    wr(5'd9, 32'hCAFEF00D, 4'hF); cyc(); idle_in();
    check("post_reset_busy", {63'h0, clr_busy}, 64'h0);
    set_rd(0, 5'd9, 32'hCAFEF00D);
    set_rd(1, 5'd5, 32'h0);
    cyc(); idle_in();
    cyc(); cyc(); cyc();
    check("no_sweep_resume", {63'h0, clr_busy}, 64'h0);

    // drain check
    cyc(); cyc();
    check("q0_empty", exp_q0.size(), 0);
    check("q1_empty", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
